// File: rtl/spu_ctrl_pkg.sv
// rtl/spu_ctrl_pkg.sv - shared types and constants for the SPU dual-issue control slice
package spu_ctrl_pkg;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } pipe_e;

    localparam int LAT_FX = 2;
    localparam int LAT_FP = 6;
    localparam int LAT_LS = 6;
    localparam int LAT_BR = 4;

    localparam int DEF_REG_W   = 7;
    localparam int DEF_LAT_W   = 3;
    localparam int DEF_NUM_SRC = 3;
    localparam int STALL_W     = 16;

    // Decoded slot at the default register-file geometry
    typedef struct packed {
        logic                                  valid;
        pipe_e                                 pipe;
        logic [DEF_NUM_SRC-1:0][DEF_REG_W-1:0] src;
        logic [DEF_NUM_SRC-1:0]                src_used;
        logic [DEF_REG_W-1:0]                  rt;
        logic                                  wr;
        logic [DEF_LAT_W-1:0]                  lat;
    } slot_t;

endpackage

// File: rtl/spu_dual_issue_ctrl_if.sv
// rtl/spu_dual_issue_ctrl_if.sv - decode-pair request and issue-decision bundle
interface spu_dual_issue_ctrl_if #(
    parameter int REG_W   = 7,
    parameter int LAT_W   = 3,
    parameter int NUM_SRC = 3
);
    logic                   flush;
    logic [1:0]             slot_valid;
    logic [1:0]             slot_pipe;
    logic [REG_W-1:0]       slot_src [2][NUM_SRC];
    logic [NUM_SRC-1:0]     slot_src_used [2];
    logic [REG_W-1:0]       slot_rt [2];
    logic [1:0]             slot_wr;
    logic [LAT_W-1:0]       slot_lat [2];
    logic [1:0]             issue;
    logic                   PC_enable;
    logic                   stall;
    logic [15:0]            stall_cnt;

    modport master (
        output flush, slot_valid, slot_pipe, slot_src, slot_src_used, slot_rt, slot_wr, slot_lat,
        input  issue, PC_enable, stall, stall_cnt
    );

    modport slave (
        input  flush, slot_valid, slot_pipe, slot_src, slot_src_used, slot_rt, slot_wr, slot_lat,
        output issue, PC_enable, stall, stall_cnt
    );
endinterface

// File: rtl/spu_scoreboard.sv
// rtl/spu_scoreboard.sv - per-register result latency counters with two write and many read ports
module spu_scoreboard #(
    parameter int NUM_REGS = 128,
    parameter int REG_W    = 7,
    parameter int LAT_W    = 3,
    parameter int NUM_SRC  = 3,
    localparam int RD_PORTS = 2 * NUM_SRC + 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [1:0]                         wr_en,
    input  logic [1:0][REG_W-1:0]              wr_idx,
    input  logic [1:0][LAT_W-1:0]              wr_lat,
    input  logic [RD_PORTS-1:0][REG_W-1:0]     rd_idx,
    output logic [RD_PORTS-1:0][LAT_W-1:0]     rd_pend
);
    logic [LAT_W-1:0] pending [NUM_REGS];

    // A fresh issue reloads the counter; the two slots never share a target
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!reset) begin
                pending[r] <= '0;
            end else if (wr_en[0] && wr_idx[0] == REG_W'(r)) begin
                pending[r] <= wr_lat[0];
            end else if (wr_en[1] && wr_idx[1] == REG_W'(r)) begin
                pending[r] <= wr_lat[1];
            end else if (pending[r] != '0) begin
                pending[r] <= pending[r] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        rd_pend = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            rd_pend[i] = pending[rd_idx[i]];
        end
    end
endmodule

// File: rtl/spu_dual_issue_ctrl.sv
// rtl/spu_dual_issue_ctrl.sv - dual-issue hazard resolution, pc-enable/stall generation and stall counter
module spu_dual_issue_ctrl
    import spu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 128,
    parameter int REG_W    = 7,
    parameter int LAT_W    = 3,
    parameter int NUM_SRC  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    spu_dual_issue_ctrl_if.slave   bus
);
    localparam int RD_PORTS = 2 * NUM_SRC + 2;

    logic [RD_PORTS-1:0][REG_W-1:0] rd_idx;
    logic [RD_PORTS-1:0][LAT_W-1:0] rd_pend;
    logic [1:0]                     wr_en;
    logic [1:0][REG_W-1:0]          wr_idx;
    logic [1:0][LAT_W-1:0]          wr_lat;
    logic [1:0]                     src_ready;
    logic [1:0]                     waw_ok;
    logic                           pair_ok;
    logic [1:0]                     issue_w;
    logic                           stall_w;
    logic [STALL_W-1:0]             stall_cnt_q;

    always_comb begin
        rd_idx = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                rd_idx[s*NUM_SRC+k] = bus.slot_src[s][k];
            end
            rd_idx[2*NUM_SRC+s] = bus.slot_rt[s];
        end
    end

    spu_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .LAT_W    (LAT_W),
        .NUM_SRC  (NUM_SRC)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_lat  (wr_lat),
        .rd_idx  (rd_idx),
        .rd_pend (rd_pend)
    );

    // A counter at 1 means the result lands on the coming edge and is forwarded,
    // so an L-cycle producer lets its consumer issue exactly L cycles later.
    always_comb begin
        src_ready = 2'b11;
        waw_ok    = 2'b00;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (bus.slot_src_used[s][k] && rd_pend[s*NUM_SRC+k] > LAT_W'(1)) begin
                    src_ready[s] = 1'b0;
                end
            end
            waw_ok[s] = !bus.slot_wr[s] || (rd_pend[2*NUM_SRC+s] <= bus.slot_lat[s]);
        end
    end

    always_comb begin
        pair_ok = (bus.slot_pipe[1] != bus.slot_pipe[0]) &&
                  !(bus.slot_wr[0] && bus.slot_wr[1] && bus.slot_rt[0] == bus.slot_rt[1]);
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.slot_wr[0] && bus.slot_src_used[1][k] && bus.slot_src[1][k] == bus.slot_rt[0]) begin
                pair_ok = 1'b0;
            end
        end
    end

    assign issue_w[0] = bus.slot_valid[0] && src_ready[0] && waw_ok[0] && !bus.flush && reset;
    assign issue_w[1] = bus.slot_valid[1] && src_ready[1] && waw_ok[1] && pair_ok && issue_w[0];
    assign stall_w    = reset && !bus.flush &&
                        ((bus.slot_valid[0] && !issue_w[0]) || (bus.slot_valid[1] && !issue_w[1]));

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wr_en[s]  = issue_w[s] && bus.slot_wr[s] && (bus.slot_lat[s] != '0);
            wr_idx[s] = bus.slot_rt[s];
            wr_lat[s] = bus.slot_lat[s];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall_w && stall_cnt_q != {STALL_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
        end
    end

    assign bus.issue     = issue_w;
    assign bus.stall     = stall_w;
    assign bus.PC_enable = reset && !stall_w;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_spu_dual_issue_ctrl.sv
// tb/tb_spu_dual_issue_ctrl.sv - directed self-checking bench for spu_dual_issue_ctrl
module tb_spu_dual_issue_ctrl;
    import spu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spu_dual_issue_ctrl_if #(.REG_W(7), .LAT_W(3), .NUM_SRC(3)) bus ();

    spu_dual_issue_ctrl #(
        .NUM_REGS (128),
        .REG_W    (7),
        .LAT_W    (3),
        .NUM_SRC  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam slot_t NONE = '0;

    function automatic slot_t mk(input pipe_e p, input logic [6:0] a, input logic [2:0] used,
                                 input logic [6:0] rt, input logic wr, input logic [2:0] lat);
        slot_t v;
        v          = '0;
        v.valid    = 1'b1;
        v.pipe     = p;
        v.src[0]   = a;
        v.src_used = used;
        v.rt       = rt;
        v.wr       = wr;
        v.lat      = lat;
        return v;
    endfunction

    task automatic drive(input int s, input slot_t v);
        bus.slot_valid[s]    = v.valid;
        bus.slot_pipe[s]     = v.pipe;
        for (int k = 0; k < 3; k++) bus.slot_src[s][k] = v.src[k];
        bus.slot_src_used[s] = v.src_used;
        bus.slot_rt[s]       = v.rt;
        bus.slot_wr[s]       = v.wr;
        bus.slot_lat[s]      = v.lat;
    endtask

    task automatic cyc(input logic rst, input logic fl, input slot_t s0, input slot_t s1);
        @(negedge clk);
        reset     = rst;
        bus.flush = fl;
        drive(0, s0);
        drive(1, s1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] iss, input logic pc, input logic st);
        chk({tag, "_issue"}, 32'(bus.issue), 32'(iss));
        chk({tag, "_pc"}, 32'(bus.PC_enable), 32'(pc));
        chk({tag, "_stall"}, 32'(bus.stall), 32'(st));
    endtask

    slot_t a0, a1, w5, r5, p0, p1, e0, o0, w3a, w3b, s0, s1, w60, r60, w7, r7;

    initial begin
        a0  = mk(PIPE_EVEN, 7'd1, 3'b001, 7'd20, 1'b1, 3'd1);
        a1  = mk(PIPE_ODD, 7'd3, 3'b001, 7'd21, 1'b1, 3'd1);
        w5  = mk(PIPE_EVEN, 7'd0, 3'b000, 7'd5, 1'b1, 3'd6);
        r5  = mk(PIPE_EVEN, 7'd5, 3'b001, 7'd0, 1'b0, 3'd0);
        p0  = mk(PIPE_EVEN, 7'd0, 3'b000, 7'd10, 1'b1, 3'd1);
        p1  = mk(PIPE_ODD, 7'd10, 3'b001, 7'd0, 1'b0, 3'd0);
        e0  = mk(PIPE_EVEN, 7'd0, 3'b000, 7'd0, 1'b0, 3'd0);
        o0  = mk(PIPE_ODD, 7'd0, 3'b000, 7'd0, 1'b0, 3'd0);
        w3a = mk(PIPE_EVEN, 7'd0, 3'b000, 7'd3, 1'b1, 3'd6);
        w3b = mk(PIPE_EVEN, 7'd0, 3'b000, 7'd3, 1'b1, 3'd2);
        s0  = mk(PIPE_EVEN, 7'd0, 3'b000, 7'd40, 1'b1, 3'd1);
        s1  = mk(PIPE_ODD, 7'd0, 3'b000, 7'd40, 1'b1, 3'd1);
        w60 = mk(PIPE_EVEN, 7'd0, 3'b000, 7'd60, 1'b1, 3'd3);
        r60 = mk(PIPE_ODD, 7'd60, 3'b001, 7'd0, 1'b0, 3'd0);
        w7  = mk(PIPE_EVEN, 7'd0, 3'b000, 7'd7, 1'b1, 3'd7);
        r7  = mk(PIPE_EVEN, 7'd7, 3'b001, 7'd0, 1'b0, 3'd0);

        reset     = 1'b0;
        bus.flush = 1'b0;
        drive(0, NONE);
        drive(1, NONE);

        // reset held with a valid pair
        cyc(1'b0, 1'b0, a0, a1);
        chk_out("rst0", 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, a0, a1);
        chk_out("rst1", 2'b00, 1'b0, 1'b0);
        chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);

        cyc(1'b1, 1'b0, a0, a1);
        chk_out("pair", 2'b11, 1'b1, 1'b0);

        // RAW on a latency-6 producer
        cyc(1'b1, 1'b0, w5, NONE);
        chk_out("raw_prod", 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, r5, NONE);
            chk_out($sformatf("raw_stall%0d", i), 2'b00, 1'b0, 1'b1);
        end
        cyc(1'b1, 1'b0, r5, NONE);
        chk_out("raw_go", 2'b01, 1'b1, 1'b0);
        chk("raw_cnt", 32'(bus.stall_cnt), 32'd5);

        // intra-pair dependency
        cyc(1'b1, 1'b0, p0, p1);
        chk_out("intra", 2'b01, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, p1, NONE);
        chk_out("intra_next", 2'b01, 1'b1, 1'b0);
        chk("intra_cnt", 32'(bus.stall_cnt), 32'd6);

        // pipe conflicts
        cyc(1'b1, 1'b0, e0, e0);
        chk_out("pipe_even", 2'b01, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, o0, o0);
        chk_out("pipe_odd", 2'b01, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, o0, NONE);
        chk_out("pipe_drain", 2'b01, 1'b1, 1'b0);
        chk("pipe_cnt", 32'(bus.stall_cnt), 32'd8);

        // WAW: r3 at 6, new writer with latency 2
        cyc(1'b1, 1'b0, w3a, NONE);
        chk_out("waw_prod", 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, w3b, NONE);
            chk_out($sformatf("waw_stall%0d", i), 2'b00, 1'b0, 1'b1);
        end
        cyc(1'b1, 1'b0, w3b, NONE);
        chk_out("waw_go", 2'b01, 1'b1, 1'b0);
        chk("waw_cnt", 32'(bus.stall_cnt), 32'd12);

        // same destination in both slots
        cyc(1'b1, 1'b0, s0, s1);
        chk_out("same_rt", 2'b01, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, s1, NONE);
        chk_out("same_rt_next", 2'b01, 1'b1, 1'b0);
        chk("same_rt_cnt", 32'(bus.stall_cnt), 32'd13);

        // flush while counters still drain
        cyc(1'b1, 1'b0, w60, NONE);
        chk_out("flush_prod", 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, a0, a1);
            chk_out($sformatf("flush%0d", i), 2'b00, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b0, r60, NONE);
        chk_out("flush_decr", 2'b01, 1'b1, 1'b0);
        chk("flush_cnt", 32'(bus.stall_cnt), 32'd13);

        // reset mid-operation drops in-flight results
        cyc(1'b1, 1'b0, w7, NONE);
        chk_out("mid_prod", 2'b01, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, r7, NONE);
        chk_out("mid_rst", 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, r7, NONE);
        chk_out("post_rst", 2'b01, 1'b1, 1'b0);
        chk("post_rst_cnt", 32'(bus.stall_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
